// File: rtl/audio_pkg.sv
// Shared types for the audio frame FIFO: default sample width, drain FSM
// state encoding and the stereo frame layout used on the storage path.
package audio_pkg;

  // Default bits per channel sample.
  localparam int AUDIO_SAMPLE_W = 24;

  // Drain state machine: pop a frame, present it, hand it to i2s_master.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } drain_state_e;

  // Stereo frame at the default width; left channel in the upper half.
  typedef struct packed {
    logic [AUDIO_SAMPLE_W-1:0] l;
    logic [AUDIO_SAMPLE_W-1:0] r;
  } frame_t;

endpackage

// File: rtl/audio_fifo_mem.sv
// Simple dual-port storage for the audio frame FIFO: one write port and one
// registered read port, written so that it maps onto block or LUT RAM.
module audio_fifo_mem #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port: store the incoming frame at the write address.
  // NOTE: the array has no reset, so tools can map it onto RAM primitives;
  // stale contents are never read because occupancy is tracked by the level.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: synchronous read, data valid the cycle after rd_en.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/audio_frame_fifo.sv
// Stereo frame FIFO between the CPU bus logic and i2s_master (clk_soc domain).
// Buffers up to 2**DEPTH_LOG2 frames, reports the fill level and raises a
// level-sensitive low-watermark interrupt. A three-state drain FSM pops one
// frame at a time and strobes it into the I2S master.
// Optional build macro AUDIO_FIFO_ZERO_FILL_EN: once streaming has started,
// an empty FIFO feeds silence frames and counts them in underrun_cnt.
module audio_frame_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5,
  parameter int SAMPLE_W   = AUDIO_SAMPLE_W,
  parameter int LOW_MARK   = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [SAMPLE_W-1:0]   in_l,
  input  logic [SAMPLE_W-1:0]   in_r,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  low_irq,
  output logic [SAMPLE_W-1:0]   frame_out_l,
  output logic [SAMPLE_W-1:0]   frame_out_r,
  output logic                  write_frame,
  input  logic                  i2s_full
`ifdef AUDIO_FIFO_ZERO_FILL_EN
  ,
  output logic [15:0]           underrun_cnt
`endif
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [LVL_W-1:0]      lvl_t;

  // Frame layout at the configured width (the package type is fixed width).
  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } stereo_t;

  localparam lvl_t FULL_LVL = lvl_t'(DEPTH);
  localparam lvl_t LOW_LVL  = lvl_t'(LOW_MARK);

  drain_state_e state, state_next;
  ptr_t         wr_ptr, rd_ptr;
  lvl_t         level_next;
  logic         push, pop;
  stereo_t      wr_frame, rd_frame;

`ifdef AUDIO_FIFO_ZERO_FILL_EN
  logic started;
  logic zero_fill;
`endif

  assign in_ready = (level != FULL_LVL);
  assign push     = in_valid && in_ready;
  assign wr_frame = '{l: in_l, r: in_r};

  audio_fifo_mem #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (2 * SAMPLE_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_frame),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (rd_frame)
  );

  // Drain FSM state register; reset abandons any frame pending in SEND.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Drain FSM next state, pop request and the i2s write strobe.
  // NOTE: every output gets a default before the case, so no latches form.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    write_frame = 1'b0;
`ifdef AUDIO_FIFO_ZERO_FILL_EN
    zero_fill   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (level != '0 && !i2s_full) begin
          pop        = 1'b1;
          state_next = FETCH;
`ifdef AUDIO_FIFO_ZERO_FILL_EN
        end else if (started && !i2s_full) begin
          zero_fill  = 1'b1;
          state_next = SEND;
`endif
        end
      end
      FETCH: begin
        state_next = SEND;
      end
      SEND: begin
        if (!i2s_full) begin
          write_frame = 1'b1;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Occupancy after this edge: push and pop in the same cycle cancel out.
  always_comb begin
    level_next = level;
    unique case ({push, pop})
      2'b10:   level_next = level + lvl_t'(1);
      2'b01:   level_next = level - lvl_t'(1);
      default: level_next = level;
    endcase
  end

  // Pointers, level and the watermark flag (taken from the next level so it
  // changes on the same edge as level and comes straight from a flop).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      low_irq <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      level   <= level_next;
      low_irq <= (level_next < LOW_LVL);
    end
  end

  // Output frame register: loaded in FETCH, held between strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_out_l <= '0;
      frame_out_r <= '0;
    end else if (state == FETCH) begin
      frame_out_l <= rd_frame.l;
      frame_out_r <= rd_frame.r;
`ifdef AUDIO_FIFO_ZERO_FILL_EN
    end else if (zero_fill) begin
      frame_out_l <= '0;
      frame_out_r <= '0;
`endif
    end
  end

`ifdef AUDIO_FIFO_ZERO_FILL_EN
  // Streaming starts with the first accepted frame; silence frames are
  // counted with saturation so firmware can spot starvation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      started      <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (push) begin
        started <= 1'b1;
      end
      if (zero_fill && underrun_cnt != 16'hFFFF) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_audio_frame_fifo.sv
// Directed self-checking bench for audio_frame_fifo (default parameters).
// A queue of expected frames tracks what was accepted; every strobe is
// compared against its head. i2s_full is held high whenever the bench is
// not draining, so the zero-fill build sees the same sequence.
`timescale 1ns/1ps
module tb_audio_frame_fifo;
  import audio_pkg::*;

  localparam int SW       = AUDIO_SAMPLE_W;
  localparam int DL2      = 5;
  localparam int LOW_MARK = 8;

  logic           clk;
  logic           resetn;
  logic [SW-1:0]  in_l, in_r;
  logic           in_valid;
  logic           in_ready;
  logic [DL2:0]   level;
  logic           low_irq;
  logic [SW-1:0]  frame_out_l, frame_out_r;
  logic           write_frame;
  logic           i2s_full;
`ifdef AUDIO_FIFO_ZERO_FILL_EN
  logic [15:0]    underrun_cnt;
`endif

  int checks = 0;
  int errors = 0;
  frame_t exp_q[$];

  audio_frame_fifo #(
    .DEPTH_LOG2 (DL2),
    .SAMPLE_W   (SW),
    .LOW_MARK   (LOW_MARK)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_l        (in_l),
    .in_r        (in_r),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .level       (level),
    .low_irq     (low_irq),
    .frame_out_l (frame_out_l),
    .frame_out_r (frame_out_r),
    .write_frame (write_frame),
    .i2s_full    (i2s_full)
`ifdef AUDIO_FIFO_ZERO_FILL_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1ns after the edge for driving and sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one frame for one edge; record it if it will be accepted.
  task automatic push_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
    in_l     = l;
    in_r     = r;
    in_valid = 1'b1;
    if (in_ready) exp_q.push_back('{l: l, r: r});
    step();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a strobe; return its data after the edge that takes it.
  task automatic wait_strobe(output logic [SW-1:0] l, output logic [SW-1:0] r,
                             output bit ok);
    ok = 1'b0;
    l  = '0;
    r  = '0;
    for (int c = 0; c < 8; c++) begin
      if (write_frame === 1'b1) begin
        l  = frame_out_l;
        r  = frame_out_r;
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
  endtask

  // Drain n frames, compare each with the expected queue, then block i2s.
  task automatic drain(input int n, input string tag);
    logic [SW-1:0] gl, gr;
    bit            ok;
    frame_t        ef;
    i2s_full = 1'b0;
    for (int i = 0; i < n; i++) begin
      wait_strobe(gl, gr, ok);
      check({tag, "_strobe"}, 64'(ok), 64'd1);
      ef = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check({tag, "_data"}, {16'd0, gl, gr}, {16'd0, ef.l, ef.r});
    end
    i2s_full = 1'b1;
  endtask

  initial begin
    logic [SW-1:0] gl, gr;
    bit            ok;
    frame_t        ef;
    int            strobes;

    resetn   = 1'b0;
    in_l     = '0;
    in_r     = '0;
    in_valid = 1'b0;
    i2s_full = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_write_frame", 64'(write_frame), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_low_irq", 64'(low_irq), 64'd1);
    check("rst_frame_out", {16'd0, frame_out_l, frame_out_r}, 64'd0);
`ifdef AUDIO_FIFO_ZERO_FILL_EN
    check("rst_underrun", 64'(underrun_cnt), 64'd0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    step();

    // Basic pass-through: strobe 3 cycles after the push edge.
    i2s_full = 1'b0;
    push_frame(24'h000001, 24'h800000);
    check("pt_level_after_push", 64'(level), 64'd1);
    check("pt_wf_c1", 64'(write_frame), 64'd0);
    step();
    check("pt_level_after_pop", 64'(level), 64'd0);
    check("pt_wf_c2", 64'(write_frame), 64'd0);
    step();
    check("pt_wf_c3", 64'(write_frame), 64'd1);
    check("pt_data", {16'd0, frame_out_l, frame_out_r}, {16'd0, 24'h000001, 24'h800000});
    void'(exp_q.pop_front());
    step();
    i2s_full = 1'b1;
    check("pt_wf_once", 64'(write_frame), 64'd0);
    check("pt_level_end", 64'(level), 64'd0);

    // Fill to full with i2s blocked; frame 33 must be dropped.
    for (int k = 1; k <= 33; k++) begin
      push_frame(SW'(k), 24'h800000 | SW'(k));
    end
    check("full_level", 64'(level), 64'd32);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_low_irq", 64'(low_irq), 64'd0);
    check("full_queue", 64'(exp_q.size()), 64'd32);
    drain(32, "full");
    check("full_drained_level", 64'(level), 64'd0);
    check("full_drained_ready", 64'(in_ready), 64'd1);

    // Backpressure while in SEND.
    push_frame(24'hABCDEF, 24'h123456);
    i2s_full = 1'b0;
    step();
    step();
    i2s_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_wf_held", 64'(write_frame), 64'd0);
      check("bp_data_stable", {16'd0, frame_out_l, frame_out_r}, {16'd0, 24'hABCDEF, 24'h123456});
    end
    i2s_full = 1'b0;
    #1;
    check("bp_wf_release", 64'(write_frame), 64'd1);
    void'(exp_q.pop_front());
    step();
    i2s_full = 1'b1;
    #1;
    check("bp_wf_single", 64'(write_frame), 64'd0);

    // Watermark: fill to 10, then drain to 0.
    for (int k = 1; k <= 10; k++) begin
      push_frame(SW'(24'h100 + k), SW'(24'h200 + k));
      check("wm_fill_level", 64'(level), 64'(k));
      check("wm_fill_irq", 64'(low_irq), 64'(k < LOW_MARK));
    end
    i2s_full = 1'b0;
    for (int k = 9; k >= 0; k--) begin
      step();
      check("wm_drain_level", 64'(level), 64'(k));
      check("wm_drain_irq", 64'(low_irq), 64'(k < LOW_MARK));
      step();
      check("wm_strobe", 64'(write_frame), 64'd1);
      ef = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check("wm_data", {16'd0, frame_out_l, frame_out_r}, {16'd0, ef.l, ef.r});
      step();
    end
    i2s_full = 1'b1;

    // Simultaneous push and pop at level 5.
    for (int k = 1; k <= 5; k++) begin
      push_frame(SW'(24'hA00 + k), SW'(24'hB00 + k));
    end
    check("sim_level_pre", 64'(level), 64'd5);
    i2s_full = 1'b0;
    push_frame(24'hA06, 24'hB06);
    check("sim_level_same", 64'(level), 64'd5);
    drain(6, "sim");
    check("sim_level_end", 64'(level), 64'd0);

    // Asynchronous reset with a frame in SEND.
    for (int k = 1; k <= 3; k++) begin
      push_frame(SW'(24'hC00 + k), SW'(24'hD00 + k));
    end
    i2s_full = 1'b0;
    step();
    step();
    check("rs_wf_before", 64'(write_frame), 64'd1);
    check("rs_level_before", 64'(level), 64'd2);
    #2;
    resetn = 1'b0;
    #1;
    check("rs_wf", 64'(write_frame), 64'd0);
    check("rs_level", 64'(level), 64'd0);
    check("rs_in_ready", 64'(in_ready), 64'd1);
    check("rs_low_irq", 64'(low_irq), 64'd1);
    check("rs_frame_out", {16'd0, frame_out_l, frame_out_r}, 64'd0);
`ifdef AUDIO_FIFO_ZERO_FILL_EN
    check("rs_underrun", 64'(underrun_cnt), 64'd0);
`endif
    exp_q.delete();
    i2s_full = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    step();
    check("rs_level_after", 64'(level), 64'd0);

    // Empty FIFO after streaming has started.
    push_frame(24'h5A5A5A, 24'hA5A5A5);
    i2s_full = 1'b0;
    wait_strobe(gl, gr, ok);
    check("uf_strobe", 64'(ok), 64'd1);
    check("uf_data", {16'd0, gl, gr}, {16'd0, 24'h5A5A5A, 24'hA5A5A5});
`ifdef AUDIO_FIFO_ZERO_FILL_EN
    check("uf_cnt0", 64'(underrun_cnt), 64'd0);
    step();
    check("uf_silence_wf", 64'(write_frame), 64'd1);
    check("uf_silence_data", {16'd0, frame_out_l, frame_out_r}, 64'd0);
    check("uf_cnt1", 64'(underrun_cnt), 64'd1);
    step();
    step();
    check("uf_cnt2", 64'(underrun_cnt), 64'd2);
    i2s_full = 1'b1;
`else
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      if (write_frame === 1'b1) strobes++;
      step();
    end
    check("uf_no_strobe", 64'(strobes), 64'd0);
    i2s_full = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_frame_fifo.md
Name: audio_frame_fifo

Overview:
- Stereo sample buffer between the CPU bus logic (producer) and i2s_master (consumer), in the clk_soc domain.
- Decouples bursty CPU writes from the steady I2S frame rate.
- Holds up to 2^DEPTH_LOG2 stereo frames.
- Exposes a fill level and a low-watermark interrupt so firmware can refill in blocks instead of polling i2s full per sample.

Parameters:
- DEPTH_LOG2, 5, log2 of FIFO depth in stereo frames (depth 32).
- SAMPLE_W, 24, bits per channel sample.
- LOW_MARK, 8, low_irq asserts while level < LOW_MARK; legal range 1..2^DEPTH_LOG2.

Ports:
- clk  in  1  clk_soc.
- resetn  in  1  async active-low reset; deassertion is synchronous to clk upstream.
- in_l  in  SAMPLE_W  left sample from bus logic.
- in_r  in  SAMPLE_W  right sample from bus logic.
- in_valid  in  1  push request, one frame per cycle.
- in_ready  out  1  FIFO can accept a frame this cycle.
- level  out  DEPTH_LOG2+1  frames currently stored, 0..2^DEPTH_LOG2.
- low_irq  out  1  level-sensitive; high while level < LOW_MARK.
- frame_out_l  out  SAMPLE_W  to i2s frame_in_l.
- frame_out_r  out  SAMPLE_W  to i2s frame_in_r.
- write_frame  out  1  one-cycle strobe to i2s write_frame.
- i2s_full  in  1  from i2s full.

Behaviour:
- Reset (async, resetn=0):
  - rd_ptr, wr_ptr, level reset to 0.
  - in_ready=1, write_frame=0, frame_out_l/r=0, low_irq=1.
  - Storage contents are don't-care.
- Push: on a rising clk edge with in_valid && in_ready, write {in_l, in_r} at wr_ptr; wr_ptr wraps modulo depth.
  - in_ready = (level != 2^DEPTH_LOG2), combinational from registered level.
  - in_valid while full is ignored; no overflow and no state change.
- Storage: a register or RAM array with one write port and one read port. The read is synchronous.
- Drain state machine, states IDLE, FETCH, SEND:
  - IDLE: if level != 0 and !i2s_full, read at rd_ptr, increment rd_ptr, go to FETCH.
  - FETCH: read data is valid; register it onto frame_out_l/r; go to SEND.
  - SEND: if i2s_full=0, assert write_frame for exactly one cycle with frame_out stable, then go to IDLE. If i2s_full=1, hold frame_out and wait in SEND.
- Latency: a push into an empty FIFO with i2s not full produces write_frame 3 cycles later.
- Throughput: at most 1 frame per 3 cycles. This is far above the audio rate.
- frame_out_l/r hold their last value between strobes.
- Level accounting:
  - level increments on push and decrements on the IDLE->FETCH pop.
  - Simultaneous push and pop leaves level unchanged.
  - A push at level 0 in the same cycle is not visible to IDLE until the next cycle.
- low_irq is registered from the next-state level (no extra lag). It must not glitch.
- Pointer wrap: both pointers are DEPTH_LOG2 bits. Full/empty status comes only from level.
- Samples pass through bit-exact; no arithmetic on data.
- Reset mid-operation: state returns to IDLE and write_frame deasserts immediately. A frame pending in SEND is discarded.

Optional Feature:
- Macro: AUDIO_FIFO_ZERO_FILL_EN.
- Defined:
  - Adds a `started` flag, set on the first accepted push after reset.
  - Adds output underrun_cnt [15:0]: saturating at 16'hFFFF, reset 0.
  - In IDLE with level==0, started=1 and i2s_full=0, the block goes directly to SEND with frame_out=0 (silence) and increments underrun_cnt.
  - This keeps the I2S stream continuous.
- Undefined:
  - Port and logic are absent.
  - An empty FIFO simply issues no write_frame.

Decomposition:
- Shared package audio_pkg:
  - SAMPLE_W default constant.
  - Drain-state enum {IDLE, FETCH, SEND}.
  - Stereo frame struct {l, r}.
- One natural sub-module: audio_fifo_mem, a simple dual-port synchronous-read memory of width 2*SAMPLE_W and depth 2^DEPTH_LOG2, so it infers BRAM/LUTRAM.
- Control and FSM stay in the top.

Test Plan:
- Basic pass-through:
  - Stimulus: push (l=24'h000001, r=24'h800000) with i2s_full=0.
  - Response: write_frame pulses once, 3 cycles after push, with matching data; level returns 0.
- Fill to full:
  - Stimulus: i2s_full=1; push 33 frames with values 1..33.
  - Response: level=32, in_ready=0, frame 33 dropped. After releasing i2s_full, frames 1..32 drain in order and wrap is correct.
- Backpressure in SEND:
  - Stimulus: raise i2s_full while in SEND for 10 cycles.
  - Response: write_frame stays 0, frame_out is stable; one strobe follows the drop of i2s_full.
- Watermark:
  - Stimulus: LOW_MARK=8; fill to 10, then drain.
  - Response: low_irq is 0 at level 8 and rises to 1 on the cycle level becomes 7.
- Simultaneous push/pop:
  - Stimulus: push on the same cycle as the IDLE->FETCH pop at level 5.
  - Response: level stays 5 and data order is preserved.
- Reset mid-SEND:
  - Stimulus: assert resetn=0 asynchronously mid-cycle.
  - Response: write_frame=0 and level=0 immediately. With AUDIO_FIFO_ZERO_FILL_EN, underrun_cnt=0, and an empty FIFO after start yields zero frames with the count incrementing.
